// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: default sizing and the stage-register record shared by the pipelined adder
package pipelined_adder_pkg;
  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;
  localparam int MAX_WIDTH      = 64;
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic                 sub;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    logic [MAX_WIDTH-1:0] res;
  } stage_t;
endpackage

// File: rtl/adder_slice.sv
// adder_slice: S-bit combinational adder slice reporting carry out and the carry into its MSB
module adder_slice #(
  parameter int S = 8
) (
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  logic         cin,
  output logic [S-1:0] s,
  output logic         cout,
  output logic         cmsb
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{S{1'b0}}, cin};
  assign cmsb = s[S-1] ^ a[S-1] ^ b[S-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: one slice per stage add/sub pipeline with valid/ready; define PIPELINED_ADDER_OVF_EN to add the ovf output
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int S = WIDTH / STAGES;
  if (STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH <= MAX_WIDTH");
  end
  stage_t            r_stage [STAGES];
  stage_t            w_in    [STAGES];
  stage_t            w_nxt   [STAGES];
  logic [STAGES-1:0] w_c;
  logic [STAGES-1:0] w_cmsb;
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_advance;
  logic              w_unused_cmsb;
  assign w_advance = !(out_valid && !out_ready);
  assign in_ready  = w_advance;
  assign w_b_eff   = sub ? ~b : b;
  assign w_in[0]   = '{valid: in_valid, carry: sub | cin, sub: sub,
                       a: MAX_WIDTH'(a), b: MAX_WIDTH'(w_b_eff), res: '0};
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [S-1:0] w_s;
    if (k > 0) begin : g_link
      assign w_in[k] = r_stage[k-1];
    end
    adder_slice #(.S(S)) u_slice (
      .a    (w_in[k].a[S-1:0]),
      .b    (w_in[k].b[S-1:0]),
      .cin  (w_in[k].carry),
      .s    (w_s),
      .cout (w_c[k]),
      .cmsb (w_cmsb[k])
    );
    assign w_nxt[k] = '{valid: w_in[k].valid, carry: w_c[k], sub: w_in[k].sub,
                        a: w_in[k].a >> S, b: w_in[k].b >> S,
                        res: (w_in[k].res >> S) | (MAX_WIDTH'(w_s) << (WIDTH - S))};
  end
  // All stages move together; the whole pipe freezes while the output beat is refused
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_stage <= '{default: '0};
    else if (w_advance) r_stage <= w_nxt;
  assign out_valid = r_stage[STAGES-1].valid;
  assign sum       = r_stage[STAGES-1].res[WIDTH-1:0];
  assign cout      = r_stage[STAGES-1].carry;
  assign w_unused_cmsb = ^w_cmsb;
`ifdef PIPELINED_ADDER_OVF_EN
  logic r_ovf;
  // Signed overflow of the top slice, registered in step with the last stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ovf <= 1'b0;
    else if (w_advance) r_ovf <= w_cmsb[STAGES-1] ^ w_c[STAGES-1];
  assign ovf = r_ovf;
`endif
endmodule
